// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Requester-side bundle between the SRAM arbiter and its two clients: the
// camera line writer (wr_*) and the DWT coefficient reader (rd_*).
//
// Signals
//   wr_req   requester -> arbiter  write request, held until wr_ack
//   wr_addr  requester -> arbiter  write word address, stable while wr_req
//   wr_data  requester -> arbiter  write data, stable while wr_req
//   wr_ack   arbiter -> requester  one-cycle pulse, write accepted
//   rd_req   requester -> arbiter  read request, held until rd_ack
//   rd_addr  requester -> arbiter  read word address
//   rd_ack   arbiter -> requester  one-cycle pulse, read issued to the SRAM
//   rd_data  arbiter -> requester  registered read data
//   rd_valid arbiter -> requester  one-cycle pulse, rd_data valid
//
// Modports
//   master  the requester side (camera writer / DWT reader)
//   slave   the arbiter side
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 32
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data, rd_valid
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one external 32-bit synchronous SRAM between the camera line writer
// (writes, highest priority, cannot be stalled) and the DWT coefficient reader
// (pipelined reads). The arbiter owns every SRAM pin including the
// bidirectional data bus, runs two-cycle write cycles, one-per-cycle pipelined
// reads, and inserts turnaround cycles whenever the bus changes direction.
// A write streak counter caps consecutive write grants while a read waits.
//
// Ports
//   clk_100          system clock, rising edge
//   rst              asynchronous active-low reset
//   req              requester bundle (sram_arbiter_if.slave)
//   address_to_sram  registered SRAM word address
//   data_sram        SRAM data bus, driven only in WR_1/WR_2, else high-Z
//   write_en_n       registered active-low write strobe
//   output_en        registered active-low output enable
//   chip_en, adv     tied low
//   byte_en          tied to all-enabled (4'b0000)
//   busy             high outside IDLE or while reads are in flight
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned WR_BURST_MAX = 4
) (
    input  logic              clk_100,
    input  logic              rst,
    sram_arbiter_if.slave     req,
    output logic [ADDR_W-1:0] address_to_sram,
    inout  wire  [DATA_W-1:0] data_sram,
    output logic              write_en_n,
    output logic              output_en,
    output logic              chip_en,
    output logic              adv,
    output logic [3:0]        byte_en,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_1,
        S_WR_2,
        S_RD_ISSUE,
        S_TURN
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(WR_BURST_MAX);

    // Registered state and outputs
    state_t                r_state;
    logic                  r_turn_to_wr;   // TURN is ahead of a write (else ahead of a read)
    logic                  r_turn_flag;    // rd_pipe has been seen empty once while in TURN
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [2:0]            r_wr_streak;
    logic                  r_wr_ack;
    logic                  r_rd_ack;
    logic                  r_rd_valid;
    logic [DATA_W-1:0]     r_rd_data;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_we_n;
    logic                  r_oe;
    logic                  r_bus_drive;
    logic                  r_busy;

    // Combinational next-state terms
    state_t                w_state_nxt;
    logic                  w_decide;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_pipe_busy;
    logic                  w_issue;
    logic                  w_wr_next;
    logic [RD_LATENCY-1:0] w_pipe_nxt;

    assign w_decide    = (r_state == S_IDLE) || (r_state == S_WR_2) || (r_state == S_RD_ISSUE);
    assign w_grant_wr  = req.wr_req && ((r_wr_streak < STREAK_MAX) || !req.rd_req);
    assign w_grant_rd  = !w_grant_wr && req.rd_req;
    assign w_pipe_busy = |r_rd_pipe;
    assign w_issue     = (r_state == S_RD_ISSUE);
    assign w_wr_next   = (w_state_nxt == S_WR_1) || (w_state_nxt == S_WR_2);

    // One bit per outstanding read; the MSB marks the cycle the SRAM presents data.
    if (RD_LATENCY > 1) begin : g_pipe_shift
        assign w_pipe_nxt = {r_rd_pipe[RD_LATENCY-2:0], w_issue};
    end else begin : g_pipe_single
        assign w_pipe_nxt = w_issue;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_WR_2, S_RD_ISSUE: begin
                if (w_grant_wr) begin
                    // Bus still owned by the SRAM (reads in flight or just issued)
                    w_state_nxt = (w_pipe_busy || (r_state == S_RD_ISSUE)) ? S_TURN : S_WR_1;
                end else if (w_grant_rd) begin
                    // Release the bus for one cycle after our own write drive
                    w_state_nxt = (r_state == S_WR_2) ? S_TURN : S_RD_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_1: w_state_nxt = S_WR_2;
            S_TURN: begin
                if (!r_turn_to_wr) begin
                    w_state_nxt = S_RD_ISSUE;
                end else if (!w_pipe_busy && r_turn_flag) begin
                    // One idle cycle after the pipe empties lets the SRAM release the bus
                    w_state_nxt = S_WR_1;
                end else begin
                    w_state_nxt = S_TURN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_turn_to_wr <= 1'b0;
            r_turn_flag  <= 1'b0;
            r_rd_pipe    <= '0;
            r_wr_streak  <= '0;
            r_wr_ack     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we_n       <= 1'b1;
            r_oe         <= 1'b1;
            r_bus_drive  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_pipe   <= w_pipe_nxt;
            r_wr_ack    <= (w_state_nxt == S_WR_1);
            r_rd_ack    <= (w_state_nxt == S_RD_ISSUE);
            r_we_n      <= !w_wr_next;
            r_bus_drive <= w_wr_next;
            r_oe        <= !((w_state_nxt == S_RD_ISSUE) || (|w_pipe_nxt));
            r_busy      <= (w_state_nxt != S_IDLE) || (|w_pipe_nxt);

            r_rd_valid  <= r_rd_pipe[RD_LATENCY-1];
            if (r_rd_pipe[RD_LATENCY-1]) begin
                r_rd_data <= data_sram;
            end

            // Write address/data latched on WR_1 entry and held through WR_2
            if (w_state_nxt == S_WR_1) begin
                r_addr  <= req.wr_addr;
                r_wdata <= req.wr_data;
            end else if (w_state_nxt == S_RD_ISSUE) begin
                r_addr  <= req.rd_addr;
            end

            if (w_decide && (w_state_nxt == S_TURN)) begin
                r_turn_to_wr <= w_grant_wr;
                r_turn_flag  <= 1'b0;
            end else if ((r_state == S_TURN) && !w_pipe_busy) begin
                r_turn_flag  <= 1'b1;
            end

            if (!req.rd_req) begin
                r_wr_streak <= '0;
            end else if (w_decide && w_grant_rd) begin
                r_wr_streak <= '0;
            end else if (w_decide && w_grant_wr && (r_wr_streak < STREAK_MAX)) begin
                r_wr_streak <= r_wr_streak + 3'd1;
            end
        end
    end

    assign data_sram       = r_bus_drive ? r_wdata : 'z;
    assign address_to_sram = r_addr;
    assign write_en_n      = r_we_n;
    assign output_en       = r_oe;
    assign busy            = r_busy;
    assign chip_en         = 1'b0;
    assign adv             = 1'b0;
    assign byte_en         = 4'b0000;

    assign req.wr_ack   = r_wr_ack;
    assign req.rd_ack   = r_rd_ack;
    assign req.rd_data  = r_rd_data;
    assign req.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    logic              clk_100 = 1'b0;
    logic              rst     = 1'b1;
    wire  [DATA_W-1:0] data_sram;
    logic [ADDR_W-1:0] address_to_sram;
    logic              write_en_n;
    logic              output_en;
    logic              chip_en;
    logic              adv;
    logic [3:0]        byte_en;
    logic              busy;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_contend = 0;
    int n_illegal = 0;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    sram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_LATENCY   (2),
        .WR_BURST_MAX (4)
    ) dut (
        .clk_100         (clk_100),
        .rst             (rst),
        .req             (bus_if),
        .address_to_sram (address_to_sram),
        .data_sram       (data_sram),
        .write_en_n      (write_en_n),
        .output_en       (output_en),
        .chip_en         (chip_en),
        .adv             (adv),
        .byte_en         (byte_en),
        .busy            (busy)
    );

    always #5 clk_100 = ~clk_100;

    // Background pattern for locations never written
    function automatic logic [31:0] pat(input logic [7:0] a);
        return 32'hA500_0000 | {16'h0000, a, a};
    endfunction

    // Synchronous SRAM model: latency 2 from the address cycle to data on the bus
    logic [31:0]  mem [0:255];
    logic [255:0] written = '0;
    logic         p1_v = 1'b0;
    logic         p2_v = 1'b0;
    logic [7:0]   p1_a = '0;
    logic [7:0]   p2_a = '0;
    logic [31:0]  model_q;

    always @(posedge clk_100) begin
        if (!write_en_n) begin
            mem[address_to_sram[7:0]]     <= data_sram;
            written[address_to_sram[7:0]] <= 1'b1;
        end
        p1_v <= write_en_n && !output_en;
        p1_a <= address_to_sram[7:0];
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    assign model_q   = written[p2_a] ? mem[p2_a] : pat(p2_a);
    assign data_sram = p2_v ? model_q : 'z;

    // Bus-ownership monitor
    always @(negedge clk_100) begin
        if (dut.r_bus_drive && p2_v) n_contend++;
        if (dut.r_bus_drive && ((dut.r_rd_pipe != '0) || !output_en)) n_illegal++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ev;
        int   nv;

        // ---------------- reset with both requests high ----------------
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 18'h00055;
        bus_if.wr_data = 32'hCAFE_0001;
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk_100);
        check_eq("rst_we_n",   write_en_n, 1);
        check_eq("rst_oe",     output_en, 1);
        check_eq("rst_addr",   address_to_sram, 0);
        check_eq("rst_wr_ack", bus_if.wr_ack, 0);
        check_eq("rst_rd_ack", bus_if.rd_ack, 0);
        check_eq("rst_rd_vld", bus_if.rd_valid, 0);
        check_eq("rst_rd_dat", bus_if.rd_data, 0);
        check_eq("rst_busy",   busy, 0);
        check_eq("rst_drive",  dut.r_bus_drive, 0);
        check_eq("rst_ties",   {chip_en, adv, byte_en}, 0);
        rst = 1'b1;
        @(negedge clk_100);
        check_eq("rst_wack1",  bus_if.wr_ack, 1);
        check_eq("rst_we1",    write_en_n, 0);
        check_eq("rst_waddr",  address_to_sram, 18'h00055);
        bus_if.wr_req = 1'b0;
        bus_if.rd_req = 1'b0;
        @(negedge clk_100);
        check_eq("rst_we2",    write_en_n, 0);
        @(negedge clk_100);
        check_eq("rst_we3",    write_en_n, 1);
        check_eq("rst_idle",   busy, 0);

        // ---------------- single write ----------------
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 18'h00010;
        bus_if.wr_data = 32'hDEAD_BEEF;
        @(negedge clk_100);
        check_eq("sw_ack",   bus_if.wr_ack, 1);
        check_eq("sw_we1",   write_en_n, 0);
        check_eq("sw_oe1",   output_en, 1);
        check_eq("sw_addr1", address_to_sram, 18'h00010);
        check_eq("sw_data1", data_sram, 32'hDEAD_BEEF);
        bus_if.wr_req = 1'b0;
        @(negedge clk_100);
        check_eq("sw_ack2",  bus_if.wr_ack, 0);
        check_eq("sw_we2",   write_en_n, 0);
        check_eq("sw_addr2", address_to_sram, 18'h00010);
        check_eq("sw_data2", data_sram, 32'hDEAD_BEEF);
        @(negedge clk_100);
        check_eq("sw_we3",   write_en_n, 1);
        check_eq("sw_busy",  busy, 0);

        // ---------------- streamed reads 0..7 ----------------
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_100);
            ev = (k <= 8);
            check_eq($sformatf("sr_ack[%0d]", k), bus_if.rd_ack, ev);
            if (ev) check_eq($sformatf("sr_addr[%0d]", k), address_to_sram, 18'(k - 1));
            ev = (k >= 4) && (k <= 11);
            check_eq($sformatf("sr_vld[%0d]", k), bus_if.rd_valid, ev);
            if (ev) check_eq($sformatf("sr_dat[%0d]", k), bus_if.rd_data, pat(8'(k - 4)));
            if (k < 8) bus_if.rd_addr = 18'(k);
            else if (k == 8) bus_if.rd_req = 1'b0;
        end
        repeat (2) @(negedge clk_100);

        // ---------------- read then write, turnaround ----------------
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = 18'h00010;
        @(negedge clk_100);
        check_eq("rw_rack",  bus_if.rd_ack, 1);
        check_eq("rw_raddr", address_to_sram, 18'h00010);
        check_eq("rw_oe1",   output_en, 0);
        bus_if.rd_req = 1'b0;
        @(negedge clk_100);
        check_eq("rw_rack2", bus_if.rd_ack, 0);
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 18'h00020;
        bus_if.wr_data = 32'h1234_5678;
        for (int m = 3; m <= 8; m++) begin
            @(negedge clk_100);
            check_eq($sformatf("rw_wack[%0d]", m), bus_if.wr_ack, (m == 6));
            check_eq($sformatf("rw_we[%0d]", m), write_en_n, !((m == 6) || (m == 7)));
            check_eq($sformatf("rw_vld[%0d]", m), bus_if.rd_valid, (m == 4));
            check_eq($sformatf("rw_oe[%0d]", m), output_en, (m >= 4));
            if (m == 4) check_eq("rw_rdat", bus_if.rd_data, 32'hDEAD_BEEF);
            if (m == 6) begin
                check_eq("rw_waddr", address_to_sram, 18'h00020);
                check_eq("rw_wdata", data_sram, 32'h1234_5678);
                bus_if.wr_req = 1'b0;
            end
        end
        repeat (2) @(negedge clk_100);

        // ---------------- fairness: both requests held ----------------
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 18'h00040;
        bus_if.wr_data = 32'hF000_0000;
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = 18'h00003;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk_100);
            ev = (k == 1) || (k == 3) || (k == 5) || (k == 7) ||
                 (k == 15) || (k == 17) || (k == 19) || (k == 21);
            check_eq($sformatf("fr_wack[%0d]", k), bus_if.wr_ack, ev);
            check_eq($sformatf("fr_rack[%0d]", k), bus_if.rd_ack, (k == 10) || (k == 24));
            ev = ((k >= 1) && (k <= 8)) || ((k >= 15) && (k <= 22));
            check_eq($sformatf("fr_we[%0d]", k), write_en_n, !ev);
            check_eq($sformatf("fr_vld[%0d]", k), bus_if.rd_valid, (k == 13));
            if (k == 13) check_eq("fr_rdat1", bus_if.rd_data, pat(8'h03));
            if (bus_if.wr_ack) begin
                bus_if.wr_addr = bus_if.wr_addr + 18'd1;
                bus_if.wr_data = bus_if.wr_data + 32'd1;
            end
            if (bus_if.rd_ack) bus_if.rd_addr = bus_if.rd_addr + 18'd1;
            if (k == 24) begin
                bus_if.wr_req = 1'b0;
                bus_if.rd_req = 1'b0;
            end
        end
        repeat (3) @(negedge clk_100);
        check_eq("fr_vld2",  bus_if.rd_valid, 1);
        check_eq("fr_rdat2", bus_if.rd_data, pat(8'h04));
        repeat (3) @(negedge clk_100);

        // ---------------- reset during a read ----------------
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = 18'h00005;
        @(negedge clk_100);
        check_eq("mr_rack", bus_if.rd_ack, 1);
        check_eq("mr_oe0",  output_en, 0);
        bus_if.rd_req = 1'b0;
        @(negedge clk_100);
        rst = 1'b0;
        #1;
        check_eq("mr_we",   write_en_n, 1);
        check_eq("mr_oe",   output_en, 1);
        check_eq("mr_addr", address_to_sram, 0);
        check_eq("mr_busy", busy, 0);
        #2 rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_100);
            if (bus_if.rd_valid) nv++;
        end
        check_eq("mr_no_vld", nv, 0);

        // ---------------- bus ownership and captured writes ----------------
        check_eq("bus_contend", n_contend, 0);
        check_eq("bus_illegal", n_illegal, 0);
        check_eq("mem_10", mem[8'h10], 32'hDEAD_BEEF);
        check_eq("mem_20", mem[8'h20], 32'h1234_5678);
        check_eq("mem_40", mem[8'h40], 32'hF000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
